// File: rtl/processor_movavg.sv
// Moving-average filter between the ADC and DAC/PWM path: N-tap circular buffer with a
// running sum, truncating divide by N, raw-sample bypass and a sticky overrun flag.
module processor_movavg #(
  parameter int unsigned DW     = 10,
  parameter int unsigned LOG2_N = 4
) (
  input  logic          sysclk,
  input  logic          rst_n,
  input  logic          data_valid,
  input  logic [DW-1:0] data_in,
  input  logic          bypass,
  input  logic          clr_ovr,
  output logic [DW-1:0] data_out,
  output logic          out_valid,
  output logic          overrun
);

  localparam int unsigned N  = 1 << LOG2_N;
  localparam int unsigned AW = DW + LOG2_N;

  typedef enum logic [1:0] {StIdle = 2'd0, StUpd = 2'd1, StOut = 2'd2} state_e;

  state_e              state_q, state_d;
  logic                dv_q;
  logic                dv_rise;
  logic                do_latch, do_upd, do_out, do_drop;
  logic [DW-1:0]       buf_q [N];
  logic [LOG2_N-1:0]   wptr_q;
  logic [AW-1:0]       acc_q;
  logic [DW-1:0]       s_reg_q;
  logic [DW-1:0]       old_reg_q;

  assign dv_rise = data_valid & ~dv_q;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (dv_rise) state_d = StUpd;
      StUpd:   state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    do_latch = (state_q == StIdle) && dv_rise;
    do_upd   = (state_q == StUpd);
    do_out   = (state_q == StOut);
    do_drop  = (state_q != StIdle) && dv_rise;
  end

  // acc always holds the exact sum of buf_q, so the full-width update cannot wrap.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q      <= 1'b0;
      wptr_q    <= '0;
      acc_q     <= '0;
      s_reg_q   <= '0;
      old_reg_q <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      dv_q      <= data_valid;
      out_valid <= do_out;
      if (do_latch) begin
        s_reg_q   <= data_in;
        old_reg_q <= buf_q[wptr_q];
      end
      if (do_upd) begin
        acc_q         <= acc_q + AW'(s_reg_q) - AW'(old_reg_q);
        buf_q[wptr_q] <= s_reg_q;
        wptr_q        <= wptr_q + LOG2_N'(1);
      end
      if (do_out) begin
        data_out <= bypass ? s_reg_q : acc_q[AW-1:LOG2_N];
      end
      // A drop in the same cycle as clr_ovr keeps the flag set.
      if (do_drop) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_processor_movavg.sv
// Scoreboard bench for processor_movavg: driver pushes model expectations, a negedge
// monitor pops and compares value and arrival cycle whenever out_valid is seen.
module tb_processor_movavg;

  localparam int DW     = 10;
  localparam int LOG2_N = 4;
  localparam int N      = 16;

  logic          sysclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          data_valid = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          bypass = 1'b0;
  logic          clr_ovr = 1'b0;
  logic [DW-1:0] data_out;
  logic          out_valid;
  logic          overrun;

  processor_movavg #(
    .DW     (DW),
    .LOG2_N (LOG2_N)
  ) dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .data_valid (data_valid),
    .data_in    (data_in),
    .bypass     (bypass),
    .clr_ovr    (clr_ovr),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .overrun    (overrun)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [DW-1:0] val;
    int            at;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   hist[$];
  exp_t mon_e;
  logic prev_ov = 1'b0;

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: last N accepted samples since reset (missing ones count as zero).
  function automatic logic [DW-1:0] model_out(input logic [DW-1:0] s, input logic byp);
    int sum = 0;
    hist.push_back(int'(s));
    if (hist.size() > N) void'(hist.pop_front());
    foreach (hist[i]) sum += hist[i];
    return byp ? s : DW'(sum / N);
  endfunction

  task automatic send(input logic [DW-1:0] s, input int hold, input int gap);
    exp_t e;
    @(negedge sysclk);
    data_in    = s;
    data_valid = 1'b1;
    e.val = model_out(s, bypass);
    e.at  = cyc + 3;
    sb.push_back(e);
    repeat (hold) @(negedge sysclk);
    data_valid = 1'b0;
    repeat (gap) @(negedge sysclk);
  endtask

  // Accepted edge followed by a second rising edge that lands while the FSM is busy.
  task automatic send_drop(input logic [DW-1:0] s, input logic clr_same);
    exp_t e;
    @(negedge sysclk);
    data_in    = s;
    data_valid = 1'b1;
    e.val = model_out(s, bypass);
    e.at  = cyc + 3;
    sb.push_back(e);
    @(negedge sysclk);
    data_valid = 1'b0;
    @(negedge sysclk);
    data_valid = 1'b1;
    clr_ovr    = clr_same;
    @(negedge sysclk);
    data_valid = 1'b0;
    clr_ovr    = 1'b0;
    repeat (3) @(negedge sysclk);
  endtask

  always @(negedge sysclk) begin
    if (out_valid) begin
      check("out_valid_width", {31'd0, prev_ov}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: data_out=%0h with nothing pending (t=%0t)", data_out, $time);
      end else begin
        mon_e = sb.pop_front();
        check("data_out", {22'd0, data_out}, {22'd0, mon_e.val});
        check("latency_cycle", cyc, mon_e.at);
      end
    end
    prev_ov = out_valid;
  end

  initial begin
    repeat (3) @(negedge sysclk);
    check("rst_data_out", {22'd0, data_out}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge sysclk);

    // Build up some state, then reset mid-UPD.
    repeat (3) send(10'h3FF, 1, 3);
    send_drop(10'h3FF, 1'b0);
    check("pre_reset_overrun", {31'd0, overrun}, 32'd1);
    @(negedge sysclk);
    data_in    = 10'h155;
    data_valid = 1'b1;
    @(negedge sysclk);
    rst_n = 1'b0;
    #1;
    check("midupd_data_out", {22'd0, data_out}, 32'd0);
    check("midupd_out_valid", {31'd0, out_valid}, 32'd0);
    check("midupd_overrun", {31'd0, overrun}, 32'd0);
    hist.delete();
    data_valid = 1'b0;
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    repeat (2) @(negedge sysclk);

    send(10'h3FF, 1, 3);
    check("after_reset_first", {22'd0, data_out}, 32'h03F);
    repeat (15) send(10'h3FF, 1, 3);
    check("ramp_16th", {22'd0, data_out}, 32'h3FF);
    send(10'h3FF, 1, 3);
    check("ramp_17th", {22'd0, data_out}, 32'h3FF);
    send(10'h000, 1, 3);
    check("step_first", {22'd0, data_out}, 32'h3BF);
    repeat (15) send(10'h000, 1, 3);
    check("step_16th", {22'd0, data_out}, 32'h000);
    repeat (8) send(10'h000, 1, 3);

    send(10'h123, 100, 3);
    check("held_no_overrun", {31'd0, overrun}, 32'd0);
    send_drop(10'h0AA, 1'b0);
    check("drop_sets_overrun", {31'd0, overrun}, 32'd1);
    @(negedge sysclk);
    clr_ovr = 1'b1;
    @(negedge sysclk);
    clr_ovr = 1'b0;
    check("clr_overrun", {31'd0, overrun}, 32'd0);
    send_drop(10'h0BB, 1'b1);
    check("set_beats_clr", {31'd0, overrun}, 32'd1);
    @(negedge sysclk);
    clr_ovr = 1'b1;
    @(negedge sysclk);
    clr_ovr = 1'b0;

    bypass = 1'b1;
    send(10'h2A5, 1, 3);
    check("bypass_raw", {22'd0, data_out}, 32'h2A5);
    bypass = 1'b0;
    send(10'h111, 1, 3);

    for (int i = 0; i < 60; i++) begin
      bypass = 1'($urandom_range(0, 1));
      send(DW'($urandom_range(0, 1023)), $urandom_range(1, 4), $urandom_range(2, 6));
    end
    bypass = 1'b0;

    repeat (10) @(negedge sysclk);
    check("pending_expectations", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
